// File: rtl/noc_shim_pkg.sv
// noc_shim_pkg: shared flit type, injector FSM states and credit sizing helper
package noc_shim_pkg;
  localparam int FLIT_W = 32;
  localparam int DEST_W = 6;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} fsm_state_e;
  typedef struct packed {
    logic [FLIT_W-1:0] data;
    logic [DEST_W-1:0] dest;
    logic              is_tail;
  } flit_t;
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/axis_multi_injector_rr_arbiter_lock.sv
// rr_arbiter_lock: combinational round-robin pick of the first requester at or above ptr, with wrap
module rr_arbiter_lock #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant_oh,
  output logic [PW-1:0] grant_idx
);
  always_comb begin
    int c;
    logic found;
    grant_oh = '0;
    grant_idx = '0;
    found = 1'b0;
    c = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!found && req[c]) begin
        found = 1'b1;
        grant_oh[c] = 1'b1;
        grant_idx = PW'(c);
      end
    end
  end
endmodule

// File: rtl/axis_multi_injector.sv
// axis_multi_injector: round-robin packet-locked AXIS merger that serializes beats into credit-throttled registered flits
module axis_multi_injector
  import noc_shim_pkg::*;
#(
  parameter int NUM_CHANNELS         = 2,
  parameter int TDATA_WIDTH          = 32,
  parameter int TID_WIDTH            = 2,
  parameter int TDEST_WIDTH          = 4,
  parameter int SERIALIZATION_FACTOR = 1,
  parameter int FLIT_BUFFER_DEPTH    = 256,
  parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
  parameter int DEST_WIDTH           = TID_WIDTH + TDEST_WIDTH,
  parameter int CREDIT_WIDTH         = credit_width(FLIT_BUFFER_DEPTH)
) (
  input  logic                                clk_noc,
  input  logic                                rst_noc,
  input  logic [NUM_CHANNELS-1:0]             axis_in_tvalid,
  output logic [NUM_CHANNELS-1:0]             axis_in_tready,
  input  logic [NUM_CHANNELS*TDATA_WIDTH-1:0] axis_in_tdata,
  input  logic [NUM_CHANNELS-1:0]             axis_in_tlast,
  input  logic [NUM_CHANNELS*TID_WIDTH-1:0]   axis_in_tid,
  input  logic [NUM_CHANNELS*TDEST_WIDTH-1:0] axis_in_tdest,
  output logic [FLIT_WIDTH-1:0]               data_out,
  output logic [DEST_WIDTH-1:0]               dest_out,
  output logic                                is_tail_out,
  output logic                                send_out,
  input  logic                                credit_in,
  output logic [CREDIT_WIDTH-1:0]             credit_count,
  output logic                                credit_err
);
  localparam int PW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int SW = SERIALIZATION_FACTOR > 1 ? $clog2(SERIALIZATION_FACTOR) : 1;
  fsm_state_e state;
  logic [PW-1:0] grant, ptr, arb_idx, sel;
  logic [NUM_CHANNELS-1:0] arb_oh, sel_oh;
  logic [SW-1:0] slice;
  logic launch, last_slice, tail;
  logic [TDATA_WIDTH-1:0] beat;
  rr_arbiter_lock #(.N(NUM_CHANNELS), .PW(PW)) u_arb (
    .req      (axis_in_tvalid),
    .ptr      (ptr),
    .grant_oh (arb_oh),
    .grant_idx(arb_idx)
  );
  // In IDLE the arbiter's pick launches its first slice in the same cycle; LOCKED only serves the latched grant.
  always_comb begin
    sel = state == IDLE ? arb_idx : grant;
    sel_oh = state == IDLE ? arb_oh : NUM_CHANNELS'(1) << grant;
    launch = !rst_noc && credit_count != '0 && |(axis_in_tvalid & sel_oh);
    last_slice = slice == SW'(SERIALIZATION_FACTOR - 1);
    beat = axis_in_tdata[sel*TDATA_WIDTH +: TDATA_WIDTH];
    tail = axis_in_tlast[sel] && last_slice;
    axis_in_tready = launch && last_slice ? sel_oh : '0;
  end
  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      state <= IDLE;
      grant <= '0;
      ptr <= '0;
      slice <= '0;
      credit_count <= CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
      credit_err <= 1'b0;
      data_out <= '0;
      dest_out <= '0;
      is_tail_out <= 1'b0;
      send_out <= 1'b0;
    end else begin
      send_out <= launch;
      is_tail_out <= launch && tail;
      if (launch) begin
        data_out <= beat[slice*FLIT_WIDTH +: FLIT_WIDTH];
        dest_out <= {axis_in_tid[sel*TID_WIDTH +: TID_WIDTH], axis_in_tdest[sel*TDEST_WIDTH +: TDEST_WIDTH]};
        slice <= last_slice ? '0 : slice + 1'b1;
        grant <= sel;
        state <= tail ? IDLE : LOCKED;
      end
      if (launch && tail)
        ptr <= sel == PW'(NUM_CHANNELS - 1) ? '0 : sel + 1'b1;
      // A returned credit with a simultaneous launch nets to zero; a return into a full counter is an overflow.
      if (launch != credit_in) begin
        if (launch)
          credit_count <= credit_count - 1'b1;
        else if (credit_count == CREDIT_WIDTH'(FLIT_BUFFER_DEPTH))
          credit_err <= 1'b1;
        else
          credit_count <= credit_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axis_multi_injector.sv
// tb_axis_multi_injector: randomized scoreboard bench with reference credit/arbitration model plus directed reset and overflow cases
module tb_axis_multi_injector;
  localparam int N = 2, TW = 32, SF = 4, FW = 8, D = 6, CW = 3;
  typedef struct packed {logic [31:0] data; logic [3:0] tdest; logic last;} beat_t;
  typedef struct packed {logic [7:0] data; logic [5:0] dest; logic tail;} exp_t;
  logic clk_noc = 1'b0, rst_noc = 1'b1;
  logic [N-1:0] tvalid, tready, tlast;
  logic [N*TW-1:0] tdata;
  logic [N*2-1:0] tid;
  logic [N*4-1:0] tdest;
  logic [FW-1:0] data_out;
  logic [5:0] dest_out;
  logic is_tail_out, send_out, credit_in, credit_err;
  logic [CW-1:0] credit_count;
  axis_multi_injector #(
    .NUM_CHANNELS(N), .TDATA_WIDTH(TW), .TID_WIDTH(2), .TDEST_WIDTH(4),
    .SERIALIZATION_FACTOR(SF), .FLIT_BUFFER_DEPTH(D)
  ) dut (
    .clk_noc(clk_noc), .rst_noc(rst_noc),
    .axis_in_tvalid(tvalid), .axis_in_tready(tready), .axis_in_tdata(tdata),
    .axis_in_tlast(tlast), .axis_in_tid(tid), .axis_in_tdest(tdest),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out), .send_out(send_out),
    .credit_in(credit_in), .credit_count(credit_count), .credit_err(credit_err)
  );
  always #5 clk_noc = ~clk_noc;
  beat_t src_q[N][$];
  exp_t exp_q[N][$];
  int total = 0, passed = 0, outstanding = 0;
  bit sb_on = 0, drv_on = 0;
  int mcc, cur, rr;
  bit merr, pend_ci, in_pkt;
  logic [N-1:0] prev_valid, drv_acc;
  beat_t drv_bt;
  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic bit drained();
    for (int c = 0; c < N; c++)
      if (src_q[c].size() != 0 || exp_q[c].size() != 0) return 0;
    return tvalid == '0 && outstanding == 0 && !credit_in;
  endfunction
  // Reference model: credits by count arithmetic, per-channel flit streams, packet lock and round-robin order.
  always @(negedge clk_noc) begin : mon
    int c;
    bit skip;
    exp_t e;
    if (sb_on) begin
      if (send_out) chk(mcc > 0, "launch_needs_credit", mcc, 1);
      if (send_out && !pend_ci) mcc--;
      else if (!send_out && pend_ci) begin
        if (mcc == D) merr = 1;
        else mcc++;
      end
      chk(credit_count == CW'(mcc), "credit_count", credit_count, mcc);
      chk(credit_err == merr, "credit_err", credit_err, merr);
      if (send_out) begin
        outstanding++;
        c = int'(dest_out[5:4]);
        if (c >= N || exp_q[c].size() == 0) chk(0, "unexpected_flit", dest_out, 0);
        else begin
          e = exp_q[c].pop_front();
          chk({data_out, dest_out, is_tail_out} == e, "flit", longint'({data_out, dest_out, is_tail_out}), longint'(e));
          if (!in_pkt) begin
            skip = 0;
            for (int j = rr; j != c; j = (j + 1) % N) if (prev_valid[j]) skip = 1;
            chk(!skip && prev_valid[c], "rr_grant", c, rr);
            in_pkt = 1;
            cur = c;
          end else chk(c == cur, "no_interleave", c, cur);
          if (e.tail) begin
            in_pkt = 0;
            rr = (c + 1) % N;
          end
        end
      end
      pend_ci = credit_in;
      prev_valid = tvalid;
    end
  end
  initial begin : drv
    forever begin
      @(negedge clk_noc);
      drv_acc = tvalid & tready;
      @(posedge clk_noc);
      #1;
      if (drv_on) begin
        for (int c = 0; c < N; c++) begin
          if (drv_acc[c]) begin
            void'(src_q[c].pop_front());
            tvalid[c] = 1'b0;
          end
          if (!tvalid[c] && src_q[c].size() > 0 && $urandom_range(0, 3) != 0) begin
            drv_bt = src_q[c][0];
            tvalid[c] = 1'b1;
            tdata[c*TW +: TW] = drv_bt.data;
            tdest[c*4 +: 4] = drv_bt.tdest;
            tlast[c] = drv_bt.last;
            tid[c*2 +: 2] = 2'(c);
          end
        end
        credit_in = outstanding > 0 && $urandom_range(0, 2) == 0;
        if (credit_in) outstanding--;
      end
    end
  end
  initial begin : main
    beat_t bt;
    int nb, n, k;
    bit done;
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    tvalid = '1; tlast = '0; tdata = '0; tid = '0; tdest = '0; credit_in = 1'b0;
    repeat (2) @(negedge clk_noc);
    chk(send_out == 0, "rst_send", send_out, 0);
    chk(tready == 0, "rst_tready", tready, 0);
    chk(credit_count == CW'(D), "rst_credits", credit_count, D);
    chk(credit_err == 0, "rst_err", credit_err, 0);
    chk({data_out, dest_out, is_tail_out} == 0, "rst_flit", {data_out, dest_out, is_tail_out}, 0);
    for (int c = 0; c < N; c++)
      for (int p = 0; p < 10; p++) begin
        nb = $urandom_range(1, 3);
        for (int b = 0; b < nb; b++) begin
          bt.data = $urandom;
          bt.tdest = 4'($urandom);
          bt.last = b == nb - 1;
          src_q[c].push_back(bt);
          for (int s = 0; s < SF; s++)
            exp_q[c].push_back({bt.data[s*8 +: 8], 2'(c), bt.tdest, bt.last && s == SF - 1});
        end
      end
    @(posedge clk_noc);
    #1;
    tvalid = '0;
    rst_noc = 1'b0;
    mcc = D; merr = 0; pend_ci = 0; in_pkt = 0; rr = 0; cur = 0; prev_valid = '0;
    sb_on = 1;
    drv_on = 1;
    done = 0;
    for (int i = 0; i < 20000 && !done; i++) begin
      @(negedge clk_noc);
      done = drained();
    end
    chk(done, "drain", done, 1);
    repeat (3) @(negedge clk_noc);
    drv_on = 0;
    @(posedge clk_noc); #1 credit_in = 1'b1;
    @(posedge clk_noc); #1 credit_in = 1'b0;
    repeat (3) @(negedge clk_noc);
    chk(credit_err == 1, "overflow_err_sticky", credit_err, 1);
    chk(credit_count == CW'(D), "overflow_count_hold", credit_count, D);
    sb_on = 0;
    @(posedge clk_noc);
    #1;
    tvalid = 2'b01; tdata[31:0] = 32'hDDCCBBAA; tlast[0] = 1'b1; tid[1:0] = 2'd0; tdest[3:0] = 4'h3;
    n = 0; k = 0;
    while (n < 2 && k < 50) begin
      @(negedge clk_noc);
      if (send_out) begin
        chk(data_out == (n == 0 ? 8'hAA : 8'hBB), "pre_reset_slice", data_out, n == 0 ? 8'hAA : 8'hBB);
        n++;
      end
      k++;
    end
    chk(n == 2, "pre_reset_flits", n, 2);
    rst_noc = 1'b1;
    @(negedge clk_noc);
    chk(send_out == 0, "mid_rst_send", send_out, 0);
    chk(credit_count == CW'(D), "mid_rst_credits", credit_count, D);
    chk(credit_err == 0, "mid_rst_err_clear", credit_err, 0);
    chk(tready == 0, "mid_rst_tready", tready, 0);
    @(posedge clk_noc);
    #1;
    rst_noc = 1'b0;
    tdata[31:0] = 32'h44332211;
    n = 0; k = 0;
    while (n < 4 && k < 50) begin
      @(negedge clk_noc);
      if (send_out) begin
        chk(data_out == exp_b[n], "post_rst_data", data_out, exp_b[n]);
        chk(is_tail_out == (n == 3), "post_rst_tail", is_tail_out, n == 3);
        chk(dest_out == 6'h03, "post_rst_dest", dest_out, 6'h03);
        n++;
        if (n == 4) tvalid = '0;
      end
      k++;
    end
    chk(n == 4, "post_rst_flits", n, 4);
    chk(credit_count == CW'(D - 4), "post_rst_credits", credit_count, D - 4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
